// File: rtl/counter_stage_ctrl.sv
// Wrapping up-counter shared by two round-robin requesters, with stage tracking,
// milestone pulses and optional hold at special values (COUNTER_STAGE_CTRL_HOLD_EN).
module counter_stage_ctrl #(
   parameter int BIT_WIDTH = 8,
   parameter int SPVALUE_1 = 200,
   parameter int SPVALUE_2 = 249
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_req,
   input  logic                 inc_req_a,
   input  logic                 inc_req_b,
   input  logic                 sp_ack,
   output logic                 gnt_a,
   output logic                 gnt_b,
   output logic [BIT_WIDTH-1:0] counts,
   output logic [2:0]           stage,
   output logic                 hit_sp1,
   output logic                 hit_sp2,
   output logic                 hit_max,
   output logic                 wrap,
   output logic                 holding
);

`ifdef COUNTER_STAGE_CTRL_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   localparam logic [BIT_WIDTH-1:0] SP1  = BIT_WIDTH'(SPVALUE_1);
   localparam logic [BIT_WIDTH-1:0] SP2  = BIT_WIDTH'(SPVALUE_2);
   localparam logic [BIT_WIDTH-1:0] MAXV = '1;
   localparam logic [BIT_WIDTH-1:0] ONE  = BIT_WIDTH'(1);

   typedef enum logic {S_RUN, S_HOLD} fsm_t;

   fsm_t                 state;
   fsm_t                 state_nxt;
   logic                 ptr_b;
   logic                 busy;
   logic                 inc;
   logic                 hit1_nxt;
   logic                 hit2_nxt;
   logic [BIT_WIDTH-1:0] cnt_nxt;

   function automatic logic [2:0] stage_of(input logic [BIT_WIDTH-1:0] c);
      if (c == '0)        return 3'd0;
      else if (c < SP1)   return 3'd1;
      else if (c == SP1)  return 3'd2;
      else if (c < SP2)   return 3'd3;
      else if (c == SP2)  return 3'd4;
      else if (c != MAXV) return 3'd5;
      else                return 3'd6;
   endfunction

   // ptr_b low means A wins a tie
   always_comb begin
      busy     = clr_req || (state == S_HOLD);
      gnt_a    = !busy && inc_req_a && (!inc_req_b || !ptr_b);
      gnt_b    = !busy && inc_req_b && (!inc_req_a || ptr_b);
      inc      = gnt_a || gnt_b;
      cnt_nxt  = counts;
      if (clr_req)
         cnt_nxt = '0;
      else if (inc)
         cnt_nxt = counts + ONE;
      hit1_nxt = inc && (cnt_nxt == SP1);
      hit2_nxt = inc && (cnt_nxt == SP2);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RUN:
            if (HOLD_EN && (hit1_nxt || hit2_nxt))
               state_nxt = S_HOLD;
         S_HOLD:
            if (sp_ack || clr_req)
               state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_RUN;
         ptr_b   <= 1'b0;
         counts  <= '0;
         stage   <= 3'd0;
         hit_sp1 <= 1'b0;
         hit_sp2 <= 1'b0;
         hit_max <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_nxt;
         counts  <= cnt_nxt;
         stage   <= stage_of(cnt_nxt);
         hit_sp1 <= hit1_nxt;
         hit_sp2 <= hit2_nxt;
         hit_max <= inc && (cnt_nxt == MAXV);
         wrap    <= inc && (cnt_nxt == '0);
         if (!busy && inc_req_a && inc_req_b)
            ptr_b <= !ptr_b;
      end
   end

   assign holding = HOLD_EN && (state == S_HOLD);

endmodule

// File: tb/tb_counter_stage_ctrl.sv
// Randomised and directed bench for counter_stage_ctrl against an
// arithmetic reference model; follows COUNTER_STAGE_CTRL_HOLD_EN like the DUT.
module tb_counter_stage_ctrl;

`ifdef COUNTER_STAGE_CTRL_HOLD_EN
   localparam bit HEN = 1'b1;
`else
   localparam bit HEN = 1'b0;
`endif

   localparam int SP1 = 200;
   localparam int SP2 = 249;
   localparam int MAXC = 255;

   logic       clk = 1'b0;
   logic       rst, clr_req, inc_req_a, inc_req_b, sp_ack;
   logic       gnt_a, gnt_b, hit_sp1, hit_sp2, hit_max, wrap, holding;
   logic [7:0] counts;
   logic [2:0] stage;

   int checks = 0;
   int failures = 0;

   int m_cnt;
   bit m_hold, m_fav_a, m_sp1, m_sp2, m_max, m_wrap;

   counter_stage_ctrl #(
      .BIT_WIDTH(8), .SPVALUE_1(SP1), .SPVALUE_2(SP2)
   ) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .inc_req_a(inc_req_a), .inc_req_b(inc_req_b), .sp_ack(sp_ack),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .counts(counts), .stage(stage),
      .hit_sp1(hit_sp1), .hit_sp2(hit_sp2), .hit_max(hit_max),
      .wrap(wrap), .holding(holding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_stage(input int c);
      if (c == 0)         return 0;
      else if (c < SP1)   return 1;
      else if (c == SP1)  return 2;
      else if (c < SP2)   return 3;
      else if (c == SP2)  return 4;
      else if (c < MAXC)  return 5;
      else                return 6;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_hold = 0; m_fav_a = 1;
      m_sp1 = 0; m_sp2 = 0; m_max = 0; m_wrap = 0;
   endtask

   task automatic step(input bit a, input bit b, input bit clr,
                       input bit ack, input bit r);
      bit ga, gb;
      @(negedge clk);
      inc_req_a = a; inc_req_b = b; clr_req = clr; sp_ack = ack; rst = r;
      #1;
      chk("counts", counts, m_cnt);
      chk("stage", stage, exp_stage(m_cnt));
      chk("hit_sp1", hit_sp1, m_sp1);
      chk("hit_sp2", hit_sp2, m_sp2);
      chk("hit_max", hit_max, m_max);
      chk("wrap", wrap, m_wrap);
      chk("holding", holding, m_hold);
      ga = 0; gb = 0;
      if (!clr && !m_hold) begin
         if (a && b) begin
            ga = m_fav_a; gb = !m_fav_a;
         end else begin
            ga = a; gb = b;
         end
      end
      if (!r) begin
         chk("gnt_a", gnt_a, ga);
         chk("gnt_b", gnt_b, gb);
         chk("gnt_excl", gnt_a & gnt_b, 0);
      end
      m_sp1 = 0; m_sp2 = 0; m_max = 0; m_wrap = 0;
      if (r) begin
         model_reset();
      end else if (clr) begin
         m_cnt = 0; m_hold = 0;
      end else begin
         if (!m_hold && a && b) m_fav_a = !m_fav_a;
         if (ga || gb) begin
            m_cnt  = (m_cnt + 1) % 256;
            m_sp1  = (m_cnt == SP1);
            m_sp2  = (m_cnt == SP2);
            m_max  = (m_cnt == MAXC);
            m_wrap = (m_cnt == 0);
            m_hold = HEN && (m_sp1 || m_sp2);
         end else if (m_hold && ack) begin
            m_hold = 0;
         end
      end
   endtask

   initial begin
      rst = 1; clr_req = 0; inc_req_a = 0; inc_req_b = 0; sp_ack = 0;
      @(posedge clk);
      model_reset();
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      // A alone up to the first special value, then release
      for (int i = 0; i < 203; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      // both requesting: alternating grants
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
      // clear with a pending request
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      // run through both holds, max and wrap with ack held
      for (int i = 0; i < 270; i++) step(1, 0, 0, 1, 0);
      // clear and ack together while holding
      for (int i = 0; i < 205; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      // reach 249, sit there, then reset
      for (int i = 0; i < 600 && m_cnt != SP2; i++)
         step(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 4000; i++)
         step($urandom_range(3) != 0, $urandom_range(3) != 0,
              $urandom_range(199) == 0, $urandom_range(4) == 0,
              $urandom_range(999) == 0);
      step(0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_stage_ctrl.md
# counter_stage_ctrl

Synthesizable controller that owns a BIT_WIDTH-bit wrapping up-counter and shares its increment port between two requesters (A, B) with round-robin arbitration. It tracks the counter's abstract stage (INITIAL, STAGE_1, SPVAL_1, STAGE_2, SPVAL_2, STAGE_3, MAXCNTS), pulses on milestone values and optionally holds counting at each special value until software acknowledges. Its `counts`/`clr`/`incr` behaviour matches the stage-abstraction properties the formal team binds to counters, so it can be checked directly against them.

## Interface
- BIT_WIDTH, 8, counter width
- SPVALUE_1, 200, first special value; legal range 0 < SPVALUE_1 < SPVALUE_2
- SPVALUE_2, 249, second special value; legal range SPVALUE_2 < 2^BIT_WIDTH-1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- clr_req  in  1  clear counter to 0; has priority over increments
- inc_req_a  in  1  requester A increment request (level)
- inc_req_b  in  1  requester B increment request (level)
- sp_ack  in  1  releases the HOLD state
- gnt_a  out  1  combinational: A's increment accepted this cycle
- gnt_b  out  1  combinational: B's increment accepted this cycle
- counts  out  BIT_WIDTH  registered counter value
- stage  out  3  registered stage: 0 INITIAL, 1 STAGE_1, 2 SPVAL_1, 3 STAGE_2, 4 SPVAL_2, 5 STAGE_3, 6 MAXCNTS; 7 never driven
- hit_sp1 / hit_sp2 / hit_max  out  1  one-cycle pulses, first cycle counts equals SPVALUE_1 / SPVALUE_2 / all-ones
- wrap  out  1  one-cycle pulse, first cycle counts is 0 after an increment from all-ones
- holding  out  1  FSM is in HOLD

## Operation
- Reset values: counts=0, stage=0, all pulses 0, holding=0, FSM=RUN, round-robin pointer favours A.
- Grant logic, per cycle:
  - no grant if clr_req or FSM=HOLD;
  - otherwise a single requester is granted;
  - if both request, the pointer's favourite is granted and the pointer flips to the other.
- At most one grant per cycle. A granted increment adds 1 modulo 2^BIT_WIDTH.
- clr_req: next cycle counts=0, stage=INITIAL, FSM=RUN. Pointer is unchanged. No pulses, including wrap.
- Stage is always consistent with counts: 0→INITIAL; 1..SP1-1→STAGE_1; SP1→SPVAL_1; SP1+1..SP2-1→STAGE_2; SP2→SPVAL_2; SP2+1..max-1→STAGE_3; max→MAXCNTS. Stage is registered together with counts, never decoded late.
- FSM RUN→HOLD: the cycle after a grant that makes counts equal SPVALUE_1 or SPVALUE_2.
- FSM HOLD→RUN: the cycle after sp_ack=1 or clr_req=1.
- sp_ack in RUN is ignored.
- Requests are never latched. Ungranted requests are dropped and requesters keep them asserted.

## Timing
- Grant to counts update latency: 1 cycle. Pulses are coincident with the new counts value.
- In HOLD the first possible grant is in the cycle after sp_ack.
- Simultaneous clr_req and sp_ack: clear wins. The result is the same RUN state.
- Reset mid-HOLD or mid-count returns all reset values on the next edge.

## Configuration
- COUNTER_STAGE_CTRL_HOLD_EN defined: HOLD behaviour as above.
- COUNTER_STAGE_CTRL_HOLD_EN undefined:
  - FSM stays in RUN; holding is tied to 0 and sp_ack is ignored;
  - counting passes special values with no grant gap;
  - hit_sp1/hit_sp2 still pulse.

## Test plan
- Reset, then inc_req_a held (HOLD_EN): grants for 200 cycles. Next cycle counts=200, stage=2, hit_sp1=1, holding=1, gnt_a=0. Pulse sp_ack: gnt_a=1 in the following cycle, then counts=201, stage=3.
- inc_req_a and inc_req_b held from reset: grants A,B,A,B…, counts +1 every cycle, never both gnts.
- At counts=57, clr_req=1 with inc_req_a=1: gnt_a=0. Next cycle counts=0, stage=0, no wrap.
- Count to 255: hit_max=1, stage=6. One more grant gives counts=0, wrap=1, stage=0.
- In HOLD at counts=249, assert rst: next cycle counts=0, holding=0. With both requests, A is granted first.
- Macro undefined, inc_req_b held: counts runs 199→200→201 on consecutive cycles, hit_sp1 pulses once, holding stays 0.
